// File: rtl/spi_sram_pkg.sv
// Shared types for the SPI SRAM arbiter and its two-way picker.
package spi_sram_pkg;

    localparam int SRAM_AW = 24;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_BUSY,
        ARB_LOCKED
    } arb_state_t;

    typedef logic port_idx_t;

endpackage

// File: rtl/arb_rr2.sv
// Two-way request picker: round-robin against the last grant, or fixed priority to port 0.
module arb_rr2
    import spi_sram_pkg::*;
(
    input  logic [1:0] valid,
    input  port_idx_t  last_gnt,
    input  logic       fixed,
    output port_idx_t  gnt
);

    // With nothing valid the pick is irrelevant: mem_en follows the chosen port's valid.
    always_comb begin
        gnt = 1'b0;
        if (fixed) begin
            gnt = !valid[0];
        end else if (valid == 2'b11) begin
            gnt = !last_gnt;
        end else begin
            gnt = valid[1];
        end
    end

endmodule

// File: rtl/spi_sram_arbiter.sv
// Shares one spi_sram_master between two byte requesters, merging sequential
// requests from the current owner into bursts and routing read data back.
module spi_sram_arbiter
    import spi_sram_pkg::*;
#(
    parameter int MAX_BURST  = 16,
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               p0_valid,
    input  logic [SRAM_AW-1:0] p0_addr,
    input  logic               p0_wr,
    input  logic [7:0]         p0_wdata,
    input  logic               p0_seq,
    output logic               p0_ready,
    output logic               p0_rvalid,
    output logic [7:0]         p0_rdata,
    input  logic               p1_valid,
    input  logic [SRAM_AW-1:0] p1_addr,
    input  logic               p1_wr,
    input  logic [7:0]         p1_wdata,
    input  logic               p1_seq,
    output logic               p1_ready,
    output logic               p1_rvalid,
    output logic [7:0]         p1_rdata,
    output logic [SRAM_AW-1:0] mem_addr,
    output logic [7:0]         mem_wdata,
    output logic               mem_en,
    output logic               mem_wr,
    output logic               mem_rburst,
    output logic               mem_wburst,
    input  logic               mem_rdy,
    input  logic [7:0]         mem_rdata
);

    localparam int CW = $clog2(MAX_BURST + 1);

    arb_state_t         state, state_nxt;
    logic               lock, pend, pend_nxt, last_wr;
    port_idx_t          last_gnt, pend_port, pick, gnt;
    logic [SRAM_AW-1:0] last_addr, last_addr_inc;
    logic [CW-1:0]      cnt;
    logic               acc, cont, capture;
    logic               own_valid, own_seq, own_wr;
    logic [SRAM_AW-1:0] own_addr;
    logic               g_valid, g_seq, g_wr;
    logic [SRAM_AW-1:0] g_addr;
    logic [7:0]         g_wdata;

    assign lock          = (state == ARB_LOCKED);
    assign last_addr_inc = last_addr + SRAM_AW'(1);

    always_comb begin
        own_valid = p0_valid;
        own_seq   = p0_seq;
        own_wr    = p0_wr;
        own_addr  = p0_addr;
        if (last_gnt) begin
            own_valid = p1_valid;
            own_seq   = p1_seq;
            own_wr    = p1_wr;
            own_addr  = p1_addr;
        end
    end

    // The owner keeps the master only while its stream stays contiguous and under the cap.
    assign cont = lock && own_valid && own_seq && (own_wr == last_wr) &&
                  (own_addr == last_addr_inc) && (cnt < CW'(MAX_BURST));

    arb_rr2 u_pick (
        .valid    ({p1_valid, p0_valid}),
        .last_gnt (last_gnt),
        .fixed    (FIXED_PRIO),
        .gnt      (pick)
    );

    assign gnt = cont ? last_gnt : pick;

    always_comb begin
        g_valid = p0_valid;
        g_seq   = p0_seq;
        g_wr    = p0_wr;
        g_addr  = p0_addr;
        g_wdata = p0_wdata;
        if (gnt) begin
            g_valid = p1_valid;
            g_seq   = p1_seq;
            g_wr    = p1_wr;
            g_addr  = p1_addr;
            g_wdata = p1_wdata;
        end
    end

    assign mem_en     = g_valid;
    assign mem_addr   = g_addr;
    assign mem_wr     = g_wr;
    assign mem_wdata  = g_wdata;
    assign mem_wburst = cont && last_wr;
    assign mem_rburst = cont && !last_wr;
    assign acc        = en && mem_rdy && mem_en;
    assign p0_ready   = acc && (gnt == 1'b0);
    assign p1_ready   = acc && (gnt == 1'b1);
    assign capture    = en && mem_rdy && pend;

    // A master-ready cycle without a new acceptance means the burst has ended.
    always_comb begin
        state_nxt = state;
        pend_nxt  = pend;
        if (acc) begin
            state_nxt = g_seq ? ARB_LOCKED : ARB_BUSY;
            pend_nxt  = !g_wr;
        end else if (en && mem_rdy) begin
            state_nxt = ARB_IDLE;
            pend_nxt  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ARB_IDLE;
            pend      <= 1'b0;
            cnt       <= '0;
            last_gnt  <= 1'b1;
            last_addr <= '0;
            last_wr   <= 1'b0;
            pend_port <= 1'b0;
            p0_rvalid <= 1'b0;
            p1_rvalid <= 1'b0;
            p0_rdata  <= 8'h00;
            p1_rdata  <= 8'h00;
        end else if (en) begin
            state     <= state_nxt;
            pend      <= pend_nxt;
            p0_rvalid <= capture && (pend_port == 1'b0);
            p1_rvalid <= capture && (pend_port == 1'b1);
            if (capture && !pend_port) p0_rdata <= mem_rdata;
            if (capture && pend_port)  p1_rdata <= mem_rdata;
            if (acc) begin
                last_addr <= g_addr;
                last_wr   <= g_wr;
                last_gnt  <= gnt;
                cnt       <= cont ? cnt + CW'(1) : CW'(1);
                pend_port <= gnt;
            end
        end
    end

endmodule

// File: doc/spi_sram_arbiter.md
# spi_sram_arbiter

- Shares one `spi_sram_master` between two byte-wide requesters:
  - port 0: 6502 core.
  - port 1: auxiliary DMA/loader.
- Arbitration is round-robin or fixed-priority.
- Sequential requests from the current owner are merged into SPI read/write bursts, up to a bounded length.
- Read bytes are routed back to the issuing port.
- The block sits between the requesters and the master's `mem_*` interface and runs on the master's clock and clock enable.

## Interface
- `MAX_BURST`, default 16: maximum accepted transfers per ownership before forced re-arbitration; ≥1.
- `FIXED_PRIO`, default 0:
  - 0 = round-robin.
  - 1 = port 0 wins every unlocked arbitration.
- `clk` in 1: system clock (master's `clk`).
- `rst_n` in 1: reset, asynchronous, active-low.
- `en` in 1: clock enable; same signal as master `en`.
- `pN_valid` in 1 (N=0,1): request valid; once high, must hold with stable fields until accepted.
- `pN_addr` in 24: byte address.
- `pN_wr` in 1: 1 = write.
- `pN_wdata` in 8: write data.
- `pN_seq` in 1: requester permits burst merging for this request.
- `pN_ready` out 1: request accepted this cycle (combinational).
- `pN_rvalid` out 1: one-cycle pulse, read data valid.
- `pN_rdata` out 8: read data.
- `mem_addr` out 24: to master.
- `mem_wdata` out 8: to master.
- `mem_en` out 1: to master.
- `mem_wr` out 1: to master.
- `mem_rburst` out 1: to master.
- `mem_wburst` out 1: to master.
- `mem_rdy` in 1: from master.
- `mem_rdata` in 8: from master.

## Operation
- **Accept.** `acc = en & mem_rdy & mem_en`. On acceptance, `pG_ready` = `acc` for the granted port G; the other port's ready is 0.
- **Grant, combinational.**
  - If `lock` is set and the owner's request continues the burst, G = owner.
  - Else, by FIXED_PRIO: port 0 if valid, otherwise port 1.
  - Else, round-robin: the valid port not equal to `last_gnt`; if only one is valid, that port.
  - `mem_addr`, `mem_wr` and `mem_wdata` mux from G.
  - `mem_en` = `pG_valid`.
- **Continuation.** The owner's request continues the burst when all of:
  - `valid & seq`;
  - `wr == last_wr`;
  - `addr == last_addr+1`, mod 2^24, so 0xFFFFFF→0x000000 counts;
  - `cnt < MAX_BURST`.
- **Burst flags.**
  - `mem_wburst` = continue & `last_wr`.
  - `mem_rburst` = continue & !`last_wr`.
  - Both are 0 whenever `lock` = 0.
- **On acc.** Registers update as follows:
  - `last_addr`/`last_wr` ← G's fields.
  - `last_gnt` ← G.
  - `cnt` ← continuing ? `cnt+1` : 1.
  - `lock` ← G's `seq`.
  - `pend` ← !`wr`.
  - `pend_port` ← G.
- **FSM.**
  - IDLE (`pend=0`, `lock=0`).
  - BUSY: a transfer is in flight, `lock=0`.
  - LOCKED: in flight, `lock=1`.
  - Any state → BUSY/LOCKED on acc.
  - BUSY/LOCKED → IDLE on an `en & mem_rdy` cycle with no acc; this clears `lock`.
- **Read return.**
  - The first `en & mem_rdy` cycle after a read acc, with `pend=1`, samples `mem_rdata`.
  - Next cycle: `p[pend_port]_rvalid`=1 and `rdata` = the sampled byte.
  - `pend` then clears, unless the same cycle accepts a new read, in which case it re-arms. Capture and new acc in the same cycle are legal and both take effect.
- **Writes** produce no response.
- **`en`=0 freezes all registers.** Ready outputs are 0. `rvalid` stays registered, so a pulse spans until the next `en` cycle.
- **Reset values.**
  - `pend`=`lock`=0, `cnt`=0, `last_gnt`=1 (port 0 wins the first round-robin), `last_addr`=0, `last_wr`=0.
  - `p*_rvalid`=0, `p*_rdata`=0x00.
  - Combinational outputs follow their inputs.
- **Reset mid-transfer.** All state clears and no `rvalid` is issued for the lost read. Integration resets the master from the same source (`rst = !rst_n`).

## Timing
- Accept is same-cycle: ready is combinational from valid and `mem_rdy`.
- Read data appears 1 clock after the master's next `mem_rdy` cycle following the acc.
- In a burst, the master samples burst flags while `mem_rdy`=0 (DATA2/DATA3). The owner's next request therefore must be valid before that point, otherwise the burst ends.
- Fairness bound: the losing valid port waits at most `MAX_BURST` owner transfers plus one.

## Structure
- Shared package `spi_sram_pkg`:
  - arbiter state enum `{ARB_IDLE, ARB_BUSY, ARB_LOCKED}`;
  - `SRAM_AW`=24;
  - port index type.
- Sub-module `arb_rr2`: 2-way round-robin/fixed-priority picker (inputs `valid[1:0]`, `last_gnt`, `fixed`; output `gnt`).
- Counter width: `$clog2(MAX_BURST+1)`.

## Test plan
Bench: arbiter plus real `spi_sram_master` (`spi_fast`=0, `spi_phase`=0, `spi_delay`=0) plus SPI SRAM model preloaded `mem[a]=a[7:0]^0x5A`.

1. Single read: p0 reads 0x000010 → `p0_ready` one cycle; `p0_rvalid` with `rdata`=0x4A; `p1_rvalid` never asserts.
2. Simultaneous reads (round-robin): p0 reads 0x000100 and p1 reads 0x000200 in the same cycle → p0 served first (0x5A), then p1 (0x5A), each `rvalid` on its own port.
3. Burst cap: p0 streams 20 sequential reads from 0x001000 with `seq`=1 while p1 holds a read → p0 gets exactly 16 accepts, then p1 is accepted; `mem_rburst` is high for transfers 2–16 only.
4. Address wrap: p1 writes 0xFFFFFF then 0x000000 with `seq`=1 → `mem_wburst` asserted, one CS-low frame, and SRAM holds both bytes.
5. `FIXED_PRIO`=1: p0 issues back-to-back reads while p1 is valid → p1 is accepted only when p0 deasserts `valid`.
6. `en` and reset: toggle `en` at 50% during a read → same `rdata`, stretched timing. Assert `rst_n`=0 mid-read → no `rvalid`; all registered outputs at reset values.
